// File: rtl/float6_divider_seq.sv
// float6_divider_seq
//   Sequential sign/exponent/mantissa divider (A / B) using radix-2 restoring
//   division, one quotient bit per clock, with valid/ready handshakes.
//
//   Optional feature macro: FLOAT6_DIV_NORMALIZE_EN
//     When defined, the raw quotient is left-normalised after division. Each
//     shift decrements the exponent by one. The NORM state is added for this.
//
//   Ports
//     clk           rising-edge clock
//     rst_n         asynchronous active-low reset
//     in_valid      operands valid
//     in_ready      block can accept operands (IDLE only)
//     sign_a/b      operand signs
//     exponent_a/b  unsigned operand exponents [EXP_W-1:0]
//     mantissa_a/b  unsigned operand mantissas [MANT_W-1:0]
//     out_valid     result valid (DONE state)
//     out_ready     consumer accepts result
//     sign_out      sign_a XNOR sign_b
//     exponent_out  signed exponent difference [EXP_W+1:0]
//     mantissa_out  quotient [QW-1:0], all ones on divide-by-zero
//     remainder     final partial remainder [MANT_W-1:0]
//     div_zero      mantissa_b was zero
module float6_divider_seq #(
  parameter int MANT_W = 6,
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic [EXP_W-1:0]        exponent_a,
  input  logic [EXP_W-1:0]        exponent_b,
  input  logic [MANT_W-1:0]       mantissa_a,
  input  logic [MANT_W-1:0]       mantissa_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_out,
  output logic [EXP_W+1:0]        exponent_out,
  output logic [MANT_W+FRAC_W-1:0] mantissa_out,
  output logic [MANT_W-1:0]       remainder,
  output logic                    div_zero
);

  localparam int QW = MANT_W + FRAC_W;
  localparam int CW = $clog2(QW);
  localparam int EW = EXP_W + 2;

  typedef enum logic [1:0] {IDLE, DIV, DONE, NORM} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [QW-1:0]     dividend_reg, dividend_next;
  logic [MANT_W-1:0] divisor_reg, divisor_next;
  logic [MANT_W-1:0] rem_reg, rem_next;
  logic [QW-1:0]     quot_reg, quot_next;
  logic              sign_reg, sign_next;
  logic [EW-1:0]     exp_reg, exp_next;
  logic              divz_reg, divz_next;

  // Trial subtraction. The shifted partial remainder is always below
  // 2*divisor, so the result lies in -divisor..divisor-1 and the top bit is
  // a reliable sign at MANT_W+1 bits.
  logic [MANT_W:0] trial;
  assign trial = {rem_reg, dividend_reg[QW-1]} - {1'b0, divisor_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      divz_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      quot_reg     <= quot_next;
      sign_reg     <= sign_next;
      exp_reg      <= exp_next;
      divz_reg     <= divz_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    quot_next     = quot_reg;
    sign_next     = sign_reg;
    exp_next      = exp_reg;
    divz_next     = divz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next     = ~(sign_a ^ sign_b);
          exp_next      = {2'b00, exponent_a} - {2'b00, exponent_b};
          dividend_next = {mantissa_a, {FRAC_W{1'b0}}};
          divisor_next  = mantissa_b;
          rem_next      = '0;
          count_next    = CW'(QW - 1);
          if (mantissa_b == '0) begin
            quot_next  = '1;
            divz_next  = 1'b1;
            state_next = DONE;
          end else begin
            quot_next  = '0;
            divz_next  = 1'b0;
            state_next = DIV;
          end
        end
      end

      DIV: begin
        dividend_next = {dividend_reg[QW-2:0], 1'b0};
        quot_next     = {quot_reg[QW-2:0], ~trial[MANT_W]};
        if (!trial[MANT_W]) begin
          rem_next = trial[MANT_W-1:0];
        end else begin
          rem_next = {rem_reg[MANT_W-2:0], dividend_reg[QW-1]};
        end
        count_next = count_reg - CW'(1);
        if (count_reg == '0) begin
`ifdef FLOAT6_DIV_NORMALIZE_EN
          state_next = NORM;
`else
          state_next = DONE;
`endif
        end
      end

`ifdef FLOAT6_DIV_NORMALIZE_EN
      NORM: begin
        // A zero quotient has no leading one; leave it alone and exit.
        if (!quot_reg[QW-1] && (quot_reg != '0)) begin
          quot_next = {quot_reg[QW-2:0], 1'b0};
          exp_next  = exp_reg - EW'(1);
        end else begin
          state_next = DONE;
        end
      end
`endif

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready     = (state_reg == IDLE);
  assign out_valid    = (state_reg == DONE);
  assign sign_out     = sign_reg;
  assign exponent_out = exp_reg;
  assign mantissa_out = quot_reg;
  assign remainder    = rem_reg;
  assign div_zero     = divz_reg;

endmodule

// File: tb/tb_float6_divider_seq.sv
// tb_float6_divider_seq
//   Table-driven bench for float6_divider_seq. Expected results are pushed
//   to a scoreboard queue at the acceptance edge and popped at the output
//   handshake. Hand-written sequences cover backpressure and reset mid-DIV.
//   Define FLOAT6_DIV_NORMALIZE_EN for both DUT and bench to check the
//   normalising build.
module tb_float6_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_a = 1'b0, sign_b = 1'b0;
  logic [4:0]  exponent_a = '0, exponent_b = '0;
  logic [5:0]  mantissa_a = '0, mantissa_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_out;
  logic [6:0]  exponent_out;
  logic [11:0] mantissa_out;
  logic [5:0]  remainder;
  logic        div_zero;

  float6_divider_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b),
    .exponent_a(exponent_a), .exponent_b(exponent_b),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exponent_out(exponent_out),
    .mantissa_out(mantissa_out), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sa;
    logic [4:0] ea;
    logic [5:0] ma;
    logic       sb;
    logic [4:0] eb;
    logic [5:0] mb;
    logic       sgn;
    int         e_raw;
    int         m_raw;
    int         e_nrm;
    int         m_nrm;
    int         rem;
    logic       dz;
    int         nsh;
  } vec_t;

  typedef struct {
    logic sgn;
    int   e;
    int   m;
    int   rem;
    logic dz;
  } exp_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  function automatic vec_t mk(logic sa, int ea, int ma, logic sb, int eb, int mb,
                              logic sgn, int er, int mr, int en, int mn,
                              int rem, logic dz, int nsh);
    vec_t v;
    v.sa = sa; v.ea = 5'(ea); v.ma = 6'(ma);
    v.sb = sb; v.eb = 5'(eb); v.mb = 6'(mb);
    v.sgn = sgn; v.e_raw = er; v.m_raw = mr; v.e_nrm = en; v.m_nrm = mn;
    v.rem = rem; v.dz = dz; v.nsh = nsh;
    return v;
  endfunction

  // Edges after the acceptance edge until out_valid is seen.
  function automatic int exp_lat(vec_t v);
    if (v.dz) return 0;
`ifdef FLOAT6_DIV_NORMALIZE_EN
    return 13 + v.nsh;
`else
    return 12;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic start_op(input vec_t v);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", int'(in_ready), 1);
    sign_a = v.sa; exponent_a = v.ea; mantissa_a = v.ma;
    sign_b = v.sb; exponent_b = v.eb; mantissa_b = v.mb;
    in_valid = 1'b1;
    @(posedge clk);
    e.sgn = v.sgn; e.rem = v.rem; e.dz = v.dz;
`ifdef FLOAT6_DIV_NORMALIZE_EN
    e.e = v.e_nrm; e.m = v.m_nrm;
`else
    e.e = v.e_raw; e.m = v.m_raw;
`endif
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    // operands are don't-care outside the acceptance edge
    sign_a = 1'($urandom_range(1)); mantissa_a = 6'($urandom_range(63));
    exponent_b = 5'($urandom_range(31)); mantissa_b = 6'($urandom_range(63));
  endtask

  task automatic wait_result(input int req_lat);
    int lat;
    int ready_seen;
    lat = 0;
    ready_seen = 0;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      if (in_ready) ready_seen = 1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) ready_seen = 1;
    chk("latency", lat, req_lat);
    chk("in_ready_low_while_busy", ready_seen, 0);
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    chk({tag, "_sign"}, int'(sign_out), int'(e.sgn));
    chk({tag, "_exponent"}, int'($signed(exponent_out)), e.e);
    chk({tag, "_mantissa"}, int'(mantissa_out), e.m);
    chk({tag, "_remainder"}, int'(remainder), e.rem);
    chk({tag, "_div_zero"}, int'(div_zero), int'(e.dz));
  endtask

  // Called at a negedge with out_valid high and out_ready high.
  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow: got output with empty queue expected none");
    end else begin
      e = sb_q.pop_front();
      chk("out_valid_at_pop", int'(out_valid), 1);
      compare_outputs("result", e);
    end
    $display("txn %0d: mant=%0d rem=%0d exp=%0d sign=%0b dz=%0b", txn,
             mantissa_out, remainder, $signed(exponent_out), sign_out, div_zero);
    txn++;
    @(negedge clk);
    chk("in_ready_after_handshake", int'(in_ready), 1);
    chk("out_valid_after_handshake", int'(out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          sa ea ma  sb eb mb  sgn er   mr    en   mn    rem dz nsh
    vecs[0] = mk(1, 10, 48, 1, 3,  6,  1,  7,   512,  5,   2048, 0,  0, 2);
    vecs[1] = mk(0, 0,  63, 1, 31, 1,  0,  -31, 4032, -31, 4032, 0,  0, 0);
    vecs[2] = mk(0, 4,  1,  0, 2,  63, 1,  2,   1,    -9,  2048, 1,  0, 11);
    vecs[3] = mk(1, 7,  37, 0, 2,  0,  0,  5,   4095, 5,   4095, 0,  1, 0);
    vecs[4] = mk(0, 5,  1,  0, 5,  63, 1,  0,   1,    -11, 2048, 1,  0, 11);
    vecs[5] = mk(1, 20, 45, 0, 9,  7,  0,  11,  411,  8,   3288, 3,  0, 3);
    vecs[6] = mk(0, 31, 50, 0, 0,  33, 1,  31,  96,   26,  3072, 32, 0, 5);
    vecs[7] = mk(1, 12, 63, 0, 12, 63, 0,  0,   64,   -5,  2048, 0,  0, 5);
    vecs[8] = mk(0, 3,  0,  0, 1,  5,  1,  2,   0,    2,   0,    0,  0, 0);
    vecs[9] = mk(1, 0,  2,  1, 0,  3,  1,  0,   42,   -6,  2688, 2,  0, 6);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_mantissa", int'(mantissa_out), 0);
    chk("reset_exponent", int'(exponent_out), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_div_zero", int'(div_zero), 0);
    chk("reset_sign", int'(sign_out), 0);
    rst_n = 1'b1;

    // Table-driven operations with immediate consumer
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i]);
      wait_result(exp_lat(vecs[i]));
      pop_check();
    end

    // Backpressure: result held for 5 cycles, InValid pulses ignored
    out_ready = 1'b0;
    start_op(vecs[5]);
    wait_result(exp_lat(vecs[5]));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sign_a = 1'($urandom_range(1)); exponent_a = 5'($urandom_range(31));
      mantissa_a = 6'($urandom_range(63)); mantissa_b = 6'($urandom_range(1, 63));
      @(negedge clk);
      chk("bp_out_valid_held", int'(out_valid), 1);
      chk("bp_in_ready_low", int'(in_ready), 0);
      if (sb_q.size() > 0) compare_outputs("bp_hold", sb_q[0]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    pop_check();

    // Asynchronous reset in the middle of DIV
    start_op(vecs[6]);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_mantissa", int'(mantissa_out), 0);
    chk("rst_mid_exponent", int'(exponent_out), 0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    start_op(vecs[2]);
    wait_result(exp_lat(vecs[2]));
    pop_check();

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
